fft_input_loader: RTL

Upstream feeder for the fully parallel FFT butterfly chain. It accepts complex samples serially, one per transfer, and writes each one into a lane of a frame register in bit-reversed order. Each completed 2^NPOINT-sample frame is presented as one wide parallel word to the first butterfly stage (STEP=0) over the valid/busy handshake. Two frame banks operate ping-pong, so the next frame fills while the previous one waits for the butterfly.

---
 rtl/fft_pkg.sv | 31 +++
 rtl/fft_input_loader_if.sv | 30 +++
 rtl/fft_frame_bank.sv | 38 +++
 rtl/fft_input_loader.sv | 113 +++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Definitions shared by the FFT input loader and the butterfly stages: bank state,
// lane slicing, the valid/busy transfer rule and a generic bit-reversal helper.
package fft_pkg;

    // Upper bound on log2(FFT size) supported by the bit-reversal helper.
    localparam int MAX_NPOINT = 16;

    typedef enum logic {
        BANK_EMPTY = 1'b0,
        BANK_FULL  = 1'b1
    } bank_state_e;

    // Lowest bit of lane 'lane' inside a flattened parallel word.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

    // A beat moves when the producer is valid and the consumer is not busy.
    function automatic logic xfer(input logic valid, input logic busy);
        return valid & ~busy;
    endfunction

    // Reverse the low 'nbits' bits of value; bits above nbits must be zero.
    function automatic logic [MAX_NPOINT-1:0] bitrev(input logic [MAX_NPOINT-1:0] value,
                                                     input int nbits);
        logic [MAX_NPOINT-1:0] rev;
        rev = {<<{value}};
        return rev >> (MAX_NPOINT - nbits);
    endfunction

endpackage

// File: rtl/fft_input_loader_if.sv
// Serial sample input and parallel frame output of the FFT input loader.
interface fft_input_loader_if #(
    parameter int WIDTH  = 16,
    parameter int NPOINT = 3
);
    localparam int LANES = 1 << NPOINT;

    logic                   din_valid;
    logic                   din_busy;
    logic                   din_first;
    logic [WIDTH-1:0]       din_real;
    logic [WIDTH-1:0]       din_imag;
    logic                   dout_valid;
    logic                   dout_busy;
    logic [WIDTH*LANES-1:0] dout_real;
    logic [WIDTH*LANES-1:0] dout_imag;
    logic                   frame_err;

    // Master drives samples and consumes frames; slave is the loader.
    modport master (
        output din_valid, din_first, din_real, din_imag, dout_busy,
        input  din_busy, dout_valid, dout_real, dout_imag, frame_err
    );

    modport slave (
        input  din_valid, din_first, din_real, din_imag, dout_busy,
        output din_busy, dout_valid, dout_real, dout_imag, frame_err
    );

endinterface

// File: rtl/fft_frame_bank.sv
// One frame bank: 2^NPOINT complex sample registers, written one lane at a time
// and read out in parallel as a flattened word.
module fft_frame_bank
    import fft_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int NPOINT = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_en,
    input  logic [NPOINT-1:0]              wr_lane,
    input  logic [WIDTH-1:0]               wr_real,
    input  logic [WIDTH-1:0]               wr_imag,
    output logic [WIDTH*(1<<NPOINT)-1:0]   lane_real,
    output logic [WIDTH*(1<<NPOINT)-1:0]   lane_imag
);
    localparam int LANES = 1 << NPOINT;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [WIDTH-1:0] real_reg;
        logic [WIDTH-1:0] imag_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                real_reg <= '0;
                imag_reg <= '0;
            end else if (wr_en && (wr_lane == NPOINT'(gi))) begin
                real_reg <= wr_real;
                imag_reg <= wr_imag;
            end
        end

        assign lane_real[lane_lo(gi, WIDTH) +: WIDTH] = real_reg;
        assign lane_imag[lane_lo(gi, WIDTH) +: WIDTH] = imag_reg;
    end

endmodule

// File: rtl/fft_input_loader.sv
// Serial-to-parallel frame loader for the FFT butterfly chain: samples land in
// (optionally bit-reversed) lanes of two ping-pong banks handed off as whole frames.
module fft_input_loader
    import fft_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int NPOINT      = 3,
    parameter bit BIT_REVERSE = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    fft_input_loader_if.slave  bus
);
    localparam int LANES = 1 << NPOINT;
    localparam int FLAT  = WIDTH * LANES;
    localparam logic [NPOINT-1:0] CNT_MAX = NPOINT'(LANES - 1);

    logic [NPOINT-1:0] wr_cnt_reg, wr_cnt_next;
    logic              wr_bank_reg, wr_bank_next;
    logic              rd_bank_reg, rd_bank_next;
    bank_state_e       bank_state_reg [2];
    bank_state_e       bank_state_next [2];
    logic              din_busy_reg;
    logic              dout_valid_reg;
    logic              frame_err_reg;

    logic              in_xfer;
    logic              out_xfer;
    logic              resync;
    logic              complete;
    logic [NPOINT-1:0] slot;
    logic [NPOINT-1:0] lane;

    logic [FLAT-1:0]   bank_real [2];
    logic [FLAT-1:0]   bank_imag [2];

    assign in_xfer  = xfer(bus.din_valid, din_busy_reg);
    assign out_xfer = xfer(dout_valid_reg, bus.dout_busy);

    // A frame start in the middle of a frame restarts filling at slot 0.
    assign resync   = in_xfer && bus.din_first && (wr_cnt_reg != '0);
    assign slot     = resync ? '0 : wr_cnt_reg;
    assign complete = in_xfer && !resync && (wr_cnt_reg == CNT_MAX);

    if (BIT_REVERSE) begin : g_rev
        assign lane = NPOINT'(bitrev(MAX_NPOINT'(slot), NPOINT));
    end else begin : g_lin
        assign lane = slot;
    end

    always_comb begin
        bank_state_next = bank_state_reg;
        wr_cnt_next     = wr_cnt_reg;
        // Only a full bank can be read and only an empty one written, so the
        // two indices never collide when both events occur together.
        if (out_xfer) begin
            bank_state_next[rd_bank_reg] = BANK_EMPTY;
        end
        if (complete) begin
            bank_state_next[wr_bank_reg] = BANK_FULL;
        end
        if (resync) begin
            wr_cnt_next = NPOINT'(1);
        end else if (in_xfer) begin
            wr_cnt_next = wr_cnt_reg + NPOINT'(1);
        end
        wr_bank_next = wr_bank_reg ^ complete;
        rd_bank_next = rd_bank_reg ^ out_xfer;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_reg     <= '0;
            wr_bank_reg    <= 1'b0;
            rd_bank_reg    <= 1'b0;
            bank_state_reg <= '{BANK_EMPTY, BANK_EMPTY};
            din_busy_reg   <= 1'b0;
            dout_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            wr_cnt_reg     <= wr_cnt_next;
            wr_bank_reg    <= wr_bank_next;
            rd_bank_reg    <= rd_bank_next;
            bank_state_reg <= bank_state_next;
            din_busy_reg   <= (bank_state_next[wr_bank_next] == BANK_FULL);
            dout_valid_reg <= (bank_state_next[rd_bank_next] == BANK_FULL);
            frame_err_reg  <= resync;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        fft_frame_bank #(
            .WIDTH  (WIDTH),
            .NPOINT (NPOINT)
        ) u_bank (
            .clk       (clk),
            .rst_n     (rst_n),
            .wr_en     (in_xfer && (wr_bank_reg == gi[0])),
            .wr_lane   (lane),
            .wr_real   (bus.din_real),
            .wr_imag   (bus.din_imag),
            .lane_real (bank_real[gi]),
            .lane_imag (bank_imag[gi])
        );
    end

    assign bus.din_busy   = din_busy_reg;
    assign bus.dout_valid = dout_valid_reg;
    assign bus.frame_err  = frame_err_reg;
    assign bus.dout_real  = bank_real[rd_bank_reg];
    assign bus.dout_imag  = bank_imag[rd_bank_reg];

endmodule
